register_file_scheduler: RTL
============================

// Module: register_file_scheduler
// PURPOSE
//   Front-end controller for register_file (accumulator memory). Accepts valid/ready write requests
//   (matrix unit results, optional accumulate) and read requests (activation path), issues them to
//   the register file, and stalls accumulate writes that would read a stale partial sum while an
//   earlier write to the same address is in flight. Tags read returns with rd_data_valid.
// PARAMETERS
//   MATRIX_WIDTH   14   words per accumulator row
//   REGISTER_DEPTH 512  accumulator rows
//   WRITE_LATENCY  7    cycles from write issue to memory update; scoreboard depth = WRITE_LATENCY-1
//   READ_LATENCY   7    cycles from read issue to rf_data_out valid
// PORTS
//   clk              in   1                          clock
//   rst              in   1                          synchronous, active-high reset
//   halt             in   1                          freeze scheduler and register file
//   wr_valid         in   1                          write request valid
//   wr_ready         out  1                          write request accepted this cycle
//   wr_addr          in   accumulator_addr_type      write row address
//   wr_data          in   word_type[MATRIX_WIDTH]    write row data
//   wr_accumulate    in   1                          add wr_data to the stored row instead of overwriting
//   rd_valid         in   1                          read request valid
//   rd_ready         out  1                          read request accepted this cycle
//   rd_addr          in   accumulator_addr_type      read row address
//   rd_data_valid    out  1                          rd_data holds a returned row
//   rd_data          out  word_type[MATRIX_WIDTH]    read row (passthrough of rf_data_out)
//   rf_enable        out  1                          register_file enable (= !halt)
//   rf_write_addr    out  accumulator_addr_type      = wr_addr
//   rf_data_in       out  word_type[MATRIX_WIDTH]    = wr_data
//   rf_write_enable  out  1                          = wr_valid & wr_ready
//   rf_accumulate    out  1                          = wr_accumulate & rf_write_enable
//   rf_read_addr     out  accumulator_addr_type      = rd_addr
//   rf_data_out      in   word_type[MATRIX_WIDTH]    register_file data_out
//   idle             out  1                          no write or read in flight
//   hazard_stalls    out  16                         count of hazard-stalled write cycles, saturating
// BEHAVIOUR
//   - Reset: scoreboard and read-tag shifters cleared; rd_data_valid=0, idle=1, hazard_stalls=0.
//     rst also resets register_file pipelines; in-flight ops are dropped (memory rows untouched or
//     already written; no partial row). rst takes priority over halt.
//   - Write scoreboard: WRITE_LATENCY-1 stages of {valid, addr}; stage0 loads {rf_write_enable, wr_addr}
//     each non-halted cycle, others shift.
//   - wr_ready = !halt & !(wr_accumulate & any valid stage addr == wr_addr). Plain writes never stall
//     (in-order pipeline keeps WAW order). Accumulate issued at cycle k after a same-address write at
//     cycle j is granted no earlier than j+WRITE_LATENCY.
//   - rd_ready = !halt & !(rf_write_enable & wr_addr == rd_addr): same-cycle same-address read deferred
//     one cycle, so a granted read observes every write granted in earlier cycles.
//   - Read tags: READ_LATENCY-stage shift of (rd_valid & rd_ready); rd_data_valid = last stage.
//   - halt=1: rf_enable=0, wr_ready=rd_ready=0, all shifters and counter hold; latencies count
//     non-halted cycles only; rd_data_valid/rd_data hold their value.
//   - idle = no valid scoreboard stage & no valid read tag.
//   - hazard_stalls += 1 on each non-halted cycle with wr_valid & !wr_ready; saturates at 16'hFFFF.
//   - Requesters must hold valid and payload stable until ready (standard valid/ready).
//   - Addresses >= REGISTER_DEPTH: passed through unchecked; the register file ignores them.
// TESTING
//   1 reset; write addr 5 data all 3 (no acc) cycle 0; read addr 5 cycle 1 -> rd_data_valid at cycle 8, words=3
//   2 acc write addr 9 data 2 cycle 0, acc write addr 9 data 4 from cycle 1 -> wr_ready low cycles 1-6,
//     granted cycle 7, hazard_stalls=6; later read addr 9 -> words=6 (row pre-cleared)
//   3 write addr 3 data 7 and read addr 3 same cycle -> rd_ready=0 that cycle, read granted next, returns 7
//   4 write then read addr 4, halt 3 cycles mid-flight -> rd_data_valid 3 cycles later than case 1, correct data
//   5 back-to-back acc writes to addrs 1,2,3,4 -> no stall, hazard_stalls=0, idle=1 7 cycles after last
//   6 read issued, rst at cycle 3 -> rd_data_valid never asserts, idle=1, hazard_stalls=0 after reset

Source files
------------

// File: rtl/register_file_scheduler.sv
// Request scheduler in front of the accumulator register file: valid/ready issue,
// accumulate read-after-write hazard stalls, and tagging of read returns.
module register_file_scheduler #(
    parameter int MATRIX_WIDTH   = 14,
    parameter int REGISTER_DEPTH = 512,
    parameter int WRITE_LATENCY  = 7,
    parameter int READ_LATENCY   = 7,
    parameter int WORD_WIDTH     = 32,
    localparam int ADDR_WIDTH    = $clog2(REGISTER_DEPTH),
    localparam int ROW_WIDTH     = MATRIX_WIDTH * WORD_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  halt,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [ROW_WIDTH-1:0]  wr_data,
    input  logic                  wr_accumulate,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_data_valid,
    output logic [ROW_WIDTH-1:0]  rd_data,
    output logic                  rf_enable,
    output logic [ADDR_WIDTH-1:0] rf_write_addr,
    output logic [ROW_WIDTH-1:0]  rf_data_in,
    output logic                  rf_write_enable,
    output logic                  rf_accumulate,
    output logic [ADDR_WIDTH-1:0] rf_read_addr,
    input  logic [ROW_WIDTH-1:0]  rf_data_out,
    output logic                  idle,
    output logic [15:0]           hazard_stalls
);

    localparam int SB_DEPTH = WRITE_LATENCY - 1;

    logic [SB_DEPTH-1:0]     sb_valid_q, sb_valid_d;
    logic [ADDR_WIDTH-1:0]   sb_addr_q [SB_DEPTH];
    logic [ADDR_WIDTH-1:0]   sb_addr_d [SB_DEPTH];
    logic [READ_LATENCY-1:0] rd_tag_q, rd_tag_d;
    logic [15:0]             stalls_q, stalls_d;
    logic                    hazard;

    // An accumulate must not read a row whose earlier write is still in the pipeline.
    always_comb begin
        hazard = 1'b0;
        for (int unsigned i = 0; i < SB_DEPTH; i++) begin
            if (sb_valid_q[i] && (sb_addr_q[i] == wr_addr)) begin
                hazard = 1'b1;
            end
        end
    end

    assign wr_ready        = !halt && !(wr_accumulate && hazard);
    assign rf_write_enable = wr_valid && wr_ready;
    assign rd_ready        = !halt && !(rf_write_enable && (wr_addr == rd_addr));

    assign rf_enable       = !halt;
    assign rf_write_addr   = wr_addr;
    assign rf_data_in      = wr_data;
    assign rf_accumulate   = wr_accumulate && rf_write_enable;
    assign rf_read_addr    = rd_addr;
    assign rd_data         = rf_data_out;
    assign rd_data_valid   = rd_tag_q[READ_LATENCY-1];
    assign idle            = !(|sb_valid_q) && !(|rd_tag_q);
    assign hazard_stalls   = stalls_q;

    always_comb begin
        sb_valid_d = sb_valid_q;
        sb_addr_d  = sb_addr_q;
        rd_tag_d   = rd_tag_q;
        stalls_d   = stalls_q;
        if (!halt) begin
            sb_valid_d[0] = rf_write_enable;
            sb_addr_d[0]  = wr_addr;
            for (int unsigned i = 1; i < SB_DEPTH; i++) begin
                sb_valid_d[i] = sb_valid_q[i-1];
                sb_addr_d[i]  = sb_addr_q[i-1];
            end
            rd_tag_d[0] = rd_valid && rd_ready;
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                rd_tag_d[i] = rd_tag_q[i-1];
            end
            if (wr_valid && !wr_ready && (stalls_q != '1)) begin
                stalls_d = stalls_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_valid_q <= '0;
            sb_addr_q  <= '{default: '0};
            rd_tag_q   <= '0;
            stalls_q   <= '0;
        end else begin
            sb_valid_q <= sb_valid_d;
            sb_addr_q  <= sb_addr_d;
            rd_tag_q   <= rd_tag_d;
            stalls_q   <= stalls_d;
        end
    end

endmodule
